// File: rtl/nr_div_seq.sv
// nr_div_seq: sequential non-restoring unsigned divider.
// One quotient bit is produced per clock by a single add/subtract row.
// A final correction step fixes a negative partial remainder. The quotient,
// remainder and div_zero outputs are registered, and done pulses for one
// cycle whenever they are updated.
//
// Handshake: an operand pair is taken on a rising edge where both
// in_valid and in_ready are high. in_ready is high only in IDLE and depends
// on state alone. in_valid outside IDLE is ignored and never queued. Operand
// inputs are only sampled on the accept edge.
module nr_div_seq #(
    parameter int DW = 4,   // dividend / quotient width (>= 2)
    parameter int VW = 2    // divisor / remainder width (>= 1, <= DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    // The partial remainder is signed. After the shift its magnitude stays
    // below 2*D, so VW+2 bits are enough to hold it.
    localparam int PW = VW + 2;
    // The iteration counter must be able to hold the value DW.
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        CORR = 2'd2,
        DZ   = 2'd3
    } state_t;

    // state is kept as a named enum so checkers can reach it hierarchically
    state_t state;
    state_t state_nxt;

    // working registers
    logic [PW-1:0] p_reg;   // signed partial remainder P
    logic [DW-1:0] q_reg;   // dividend shifting out / quotient shifting in
    logic [VW-1:0] d_reg;   // latched divisor D
    logic [CW-1:0] cnt;     // iterations still to perform

    // combinational step terms
    logic          accept;
    logic          last_iter;
    logic          div_by_zero_in;
    logic [PW-1:0] d_ext;
    logic [PW-1:0] p_shift;
    logic [PW-1:0] p_step;
    logic [DW-1:0] q_step;
    logic [VW-1:0] rem_fix;

    // ------------------------------------------------------------------
    // Handshake and status decode
    // ------------------------------------------------------------------
    assign busy           = (state != IDLE);
    assign in_ready       = ~busy;
    assign accept         = in_valid & in_ready;
    assign div_by_zero_in = (divisor == '0);
    assign last_iter      = (cnt == CW'(1));

    // ------------------------------------------------------------------
    // Single non-restoring iteration row
    // ------------------------------------------------------------------
    // Shift {P,Q} left by one. Add D if the old P was negative, otherwise
    // subtract D. The new quotient bit is the inverted sign of the new P.
    always_comb begin
        d_ext   = {2'b00, d_reg};
        p_shift = {p_reg[PW-2:0], q_reg[DW-1]};
        p_step  = p_shift;
        if (p_reg[PW-1]) begin
            p_step = p_shift + d_ext;
        end else begin
            p_step = p_shift - d_ext;
        end
        q_step = {q_reg[DW-2:0], ~p_step[PW-1]};
    end

    // ------------------------------------------------------------------
    // Remainder correction
    // ------------------------------------------------------------------
    // A negative final P is restored by adding D once. The corrected
    // value lies in [0, D), so it fits in VW bits. The low VW bits of
    // P + D are therefore computed directly, modulo 2^VW.
    always_comb begin
        rem_fix = p_reg[VW-1:0];
        if (p_reg[PW-1]) begin
            rem_fix = p_reg[VW-1:0] + d_reg;
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // Synchronous active-low reset returns to IDLE and abandons any
    // division that is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    // IDLE -> ITER (or DZ for a zero divisor) on accept.
    // ITER runs DW times, then CORR.
    // CORR and DZ each last one cycle and return to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = div_by_zero_in ? DZ : ITER;
                end
            end
            ITER: begin
                if (last_iter) begin
                    state_nxt = CORR;
                end
            end
            CORR:    state_nxt = IDLE;
            DZ:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Working datapath registers
    // ------------------------------------------------------------------
    // On accept: load operands, clear P and arm the counter.
    // In ITER: advance one quotient bit per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_reg <= '0;
            q_reg <= '0;
            d_reg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        p_reg <= '0;
                        q_reg <= dividend;
                        d_reg <= divisor;
                        cnt   <= CW'(DW);
                    end
                end
                ITER: begin
                    p_reg <= p_step;
                    q_reg <= q_step;
                    cnt   <= cnt - CW'(1);
                end
                default: begin
                    p_reg <= p_reg;
                    q_reg <= q_reg;
                    d_reg <= d_reg;
                    cnt   <= cnt;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result registers and done pulse
    // ------------------------------------------------------------------
    // Results update only in CORR or DZ, and then hold until the next
    // update. done is high exactly in the cycle after that update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == CORR) begin
                quotient  <= q_reg;
                remainder <= rem_fix;
                div_zero  <= 1'b0;
                done      <= 1'b1;
            end else if (state == DZ) begin
                quotient  <= '1;
                remainder <= '0;
                div_zero  <= 1'b1;
                done      <= 1'b1;
            end
        end
    end

endmodule
